// File: rtl/seq_nextstate_reg_if.sv
// Bus bundle for the "1101" detector: serial input side plus state/flag outputs.
// SEQ_HIT_CNT_EN adds the hit_cnt signal.
`timescale 1ns/1ps
interface seq_nextstate_reg_if
`ifdef SEQ_HIT_CNT_EN
   #(parameter int unsigned CNT_W = 8)
`endif
   ;
   logic       in;
   logic       in_valid;
   logic       clr;
   logic [1:0] currstate;
   logic       in_s;
   logic       vld_s;
   logic       hit;
`ifdef SEQ_HIT_CNT_EN
   logic [CNT_W-1:0] hit_cnt;

   modport master (output in, in_valid, clr,
                   input  currstate, in_s, vld_s, hit, hit_cnt);
   modport slave  (input  in, in_valid, clr,
                   output currstate, in_s, vld_s, hit, hit_cnt);
`else
   modport master (output in, in_valid, clr,
                   input  currstate, in_s, vld_s, hit);
   modport slave  (input  in, in_valid, clr,
                   output currstate, in_s, vld_s, hit);
`endif
endinterface

// File: rtl/seq_nextstate_reg.sv
// Input synchronizer, next-state logic and state register of the overlapping "1101" Mealy detector.
// Define SEQ_HIT_CNT_EN to add the saturating hit counter (hit_cnt).
`timescale 1ns/1ps
module seq_nextstate_reg #(
   parameter int unsigned SYNC_STAGES = 2
`ifdef SEQ_HIT_CNT_EN
   , parameter int unsigned CNT_W = 8
`endif
) (
   input logic                clk,
   input logic                reset,
   seq_nextstate_reg_if.slave bus
);

   localparam logic [1:0] S0 = 2'b00;
   localparam logic [1:0] S1 = 2'b01;
   localparam logic [1:0] S2 = 2'b10;
   localparam logic [1:0] S3 = 2'b11;

   logic [SYNC_STAGES-1:0] in_sync_q;
   logic [SYNC_STAGES-1:0] in_sync_d;
   logic [SYNC_STAGES-1:0] vld_sync_q;
   logic [SYNC_STAGES-1:0] vld_sync_d;
   logic [1:0]             state_q;
   logic [1:0]             state_d;
   logic                   hit_q;
   logic                   hit_d;
   logic                   in_s;
   logic                   vld_s;
   logic                   det;

   // Synchronizer chain: stage 0 samples the async pins, last stage feeds the FSM.
   always_comb begin
      in_sync_d     = in_sync_q;
      vld_sync_d    = vld_sync_q;
      in_sync_d[0]  = bus.in;
      vld_sync_d[0] = bus.in_valid;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
         in_sync_d[i]  = in_sync_q[i-1];
         vld_sync_d[i] = vld_sync_q[i-1];
      end
   end

   assign in_s  = in_sync_q[SYNC_STAGES-1];
   assign vld_s = vld_sync_q[SYNC_STAGES-1];

   // Next state and detection; clr overrides stepping and discards a same-cycle detect.
   always_comb begin
      state_d = state_q;
      det     = vld_s & (state_q == S3) & in_s;
      if (vld_s) begin
         case (state_q)
            S0: state_d = in_s ? S1 : S0;
            S1: state_d = in_s ? S2 : S0;
            S2: state_d = in_s ? S2 : S3;
            S3: state_d = in_s ? S1 : S0;
         endcase
      end
      if (bus.clr) begin
         state_d = S0;
      end
      hit_d = det & ~bus.clr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_sync_q  <= '0;
         vld_sync_q <= '0;
         state_q    <= S0;
         hit_q      <= 1'b0;
      end else begin
         in_sync_q  <= in_sync_d;
         vld_sync_q <= vld_sync_d;
         state_q    <= state_d;
         hit_q      <= hit_d;
      end
   end

   assign bus.currstate = state_q;
   assign bus.in_s      = in_s;
   assign bus.vld_s     = vld_s;
   assign bus.hit       = hit_q;

`ifdef SEQ_HIT_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Saturating detection count; stops at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (bus.clr) begin
         cnt_d = '0;
      end else if (det && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus.hit_cnt = cnt_q;
`endif

endmodule
